fifo_stream_rd: RTL
===================

Name: fifo_stream_rd

Overview:
- Read-side drain stage that sits directly downstream of the team's synchronous FIFO.
- Pops the FIFO through its rd_en / rd_data / empty interface, where data is registered one cycle after a qualified rd_en.
- Re-times the popped words into a valid/ready stream, with full-throughput backpressure and a fixed-length burst framing flag (m_last).
- Absorbs the FIFO's one-cycle read latency in a small internal buffer, so downstream logic never has to track it.

Parameters:
DATA_WIDTH, 8, width of each data word; matches the FIFO word width.
BURST_LEN, 4, beats per burst; m_last is asserted on every BURST_LEN-th accepted beat; legal range >= 1.
CNT_WIDTH, $clog2(BURST_LEN+1), width of the internal beat counter; derived, not to be overridden.

Ports:
clk  in  1  single clock; all state changes on its rising edge.
rst  in  1  reset, asynchronous and active-high; forces all state to reset values immediately.
fifo_empty  in  1  FIFO empty flag.
fifo_rd_data  in  DATA_WIDTH  FIFO read data; valid in the cycle after fifo_rd_en was high.
fifo_rd_en  out  1  FIFO pop request.
m_valid  out  1  output beat valid.
m_ready  in  1  downstream accept.
m_data  out  DATA_WIDTH  output beat data.
m_last  out  1  final beat of the current burst.
occupancy  out  2  number of words held in the internal buffer (0..3).

Behaviour:
- Internal state:
  - 3-entry circular buffer with 2-bit write/read pointers and a 2-bit count.
  - inflight register, equal to fifo_rd_en delayed by one cycle.
  - Beat counter of width CNT_WIDTH.
- fifo_rd_en:
  - Equation: fifo_rd_en = !rst && !fifo_empty && (count + inflight < 3).
  - Depends only on registered state and fifo_empty; no combinational path from m_ready.
- Capture: when inflight==1, fifo_rd_data is written into buffer[wptr] at the end of that cycle; wptr advances modulo 3.
- Latency: fifo_rd_en high in cycle N -> word available on fifo_rd_data in cycle N+1 -> captured at end of N+1 -> m_valid high in cycle N+2.
- Steady state: with FIFO non-empty and m_ready=1, one beat per cycle (count=1, inflight=1).
- Output:
  - m_valid = (count != 0).
  - m_data = buffer[rptr].
  - A handshake is m_valid && m_ready; it advances rptr modulo 3.
- Count: capture-only -> +1; handshake-only -> -1; both in the same cycle -> unchanged.
- Overflow safety: the invariant count + inflight <= 3 guarantees the buffer never overflows. A verification assertion is required for this invariant.
- Stability: while m_valid && !m_ready, m_data and m_last are held stable.
- Burst framing:
  - m_last = m_valid && (beat_cnt == BURST_LEN-1).
  - On each handshake, beat_cnt increments; on the handshake with m_last=1 it wraps to 0.
  - BURST_LEN=1 -> m_last=1 on every valid beat.
  - FIFO-empty gaps do not reset beat_cnt; bursts span gaps.
- Ordering: words exit in exactly the order they were popped; there is no drop or duplication.
- Reset:
  - Clears count, pointers, inflight and beat_cnt.
  - m_valid=0, m_last=0, occupancy=0, fifo_rd_en=0.
  - m_data is don't-care while m_valid=0; buffer contents are not reset.
  - Reset mid-operation: in-flight data and buffered words are discarded; after release, the next accepted beat is beat 0 of a new burst.
- FIFO contract: the FIFO also gates rd_en with !empty; this block never asserts fifo_rd_en while fifo_empty=1.

Decomposition:
- Package fifo_stream_pkg holds:
  - constant RD_BUF_DEPTH=3;
  - constant RD_LATENCY=1;
  - function ptr_inc(p) implementing modulo-3 increment.
- Sub-module stream_skid_buf3 holds the 3-entry buffer, pointers, count, push/pop and occupancy.
- The top level holds the issue logic, inflight register and burst counter.

Test Plan:
1. Reset: hold rst=1 with fifo_empty=0 and m_ready=1 -> fifo_rd_en=0, m_valid=0, m_last=0, occupancy=0; async clear is visible before the next clk edge.
2. Streaming: FIFO model preloaded with 0x10..0x17, m_ready=1, BURST_LEN=4.
   - fifo_rd_en is high for 8 consecutive cycles starting at cycle N.
   - m_valid is high for cycles N+2..N+9 with m_data 0x10..0x17.
   - m_last is high only on 0x13 and 0x17.
3. Backpressure: same preload, m_ready=0.
   - Exactly 3 pops are issued, then fifo_rd_en stays 0.
   - occupancy=3 and m_data=0x10 is held stable.
   - Raise m_ready -> 0x10..0x17 come out in order at one beat per cycle once steady.
4. Empty gap: push 0x20,0x21, then 5 idle cycles, then push 0x22,0x23, with m_ready=1 -> m_valid drops during the gap and m_last is asserted on 0x23 (the burst spans the gap).
5. Reset mid-burst: after 2 accepted beats (0x30,0x31), pulse rst between clock edges -> outputs clear immediately. After release, a fresh preload 0x40..0x43 yields m_last on 0x43 only; 0x32 never appears.
6. Random: random fifo_empty and m_ready toggling over 1000 words with a scoreboard -> no loss, duplication or reorder; count+inflight<=3 assertion never fires; m_data stable under stall.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg
//   Constants and helpers shared by the FIFO read-drain stage.
//   RD_BUF_DEPTH : entries in the re-timing buffer
//   RD_LATENCY   : FIFO read latency (rd_en -> rd_data) absorbed by the buffer
//   ptr_inc      : modulo-RD_BUF_DEPTH pointer increment
package fifo_stream_pkg;

  localparam int RD_BUF_DEPTH = 3;
  localparam int RD_LATENCY   = 1;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/stream_skid_buf3.sv
// stream_skid_buf3
//   3-entry circular buffer that turns captured FIFO words into a
//   valid/ready stream.
//   clk, rst       : clock, async active-high reset (pointers/count only)
//   push_i         : write push_data_i this cycle
//   push_data_i    : word to capture
//   pop_ready_i    : downstream ready; a pop happens when valid_o && pop_ready_i
//   valid_o        : buffer non-empty
//   data_o         : head-of-buffer word
//   count_o        : words currently held (0..3)
module stream_skid_buf3
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic [1:0] count_q, count_d;
  logic       pop;

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign pop     = valid_o && pop_ready_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = ptr_inc(wptr_q);
    if (pop)    rptr_d = ptr_inc(rptr_q);
    // simultaneous push and pop leaves the count unchanged
    case ({push_i, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 2'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale contents are masked by count_q == 0.
  // A push never lands on the head entry while it is valid because the
  // issue logic keeps count + inflight <= depth.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fifo_stream_rd.sv
// fifo_stream_rd
//   Drains a synchronous FIFO (1-cycle registered read) into a valid/ready
//   stream with fixed-length burst framing.
//   clk, rst      : clock, async active-high reset
//   fifo_empty    : FIFO empty flag
//   fifo_rd_data  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    : FIFO pop request
//   m_valid/m_ready/m_data/m_last : output stream, m_last on every
//                   BURST_LEN-th accepted beat
//   occupancy     : words held in the internal buffer
module fifo_stream_rd
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = $clog2(BURST_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            occupancy
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  logic                 inflight_q;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [2:0]           committed;
  logic                 hs;

  // Slots already spoken for: buffered words plus the word still in the
  // FIFO's read register. Issue only from registered state so there is no
  // combinational path from m_ready to fifo_rd_en.
  assign committed  = {1'b0, occupancy} + {2'b00, inflight_q};
  assign fifo_rd_en = !rst && !fifo_empty && (committed < 3'(RD_BUF_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= fifo_rd_en;
  end

  stream_skid_buf3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_rd_data),
    .pop_ready_i (m_ready),
    .valid_o     (m_valid),
    .data_o      (m_data),
    .count_o     (occupancy)
  );

  assign hs     = m_valid && m_ready;
  assign m_last = m_valid && (beat_cnt_q == LAST_BEAT);

  // Beat position survives FIFO-empty gaps; only reset starts a new burst.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (hs) beat_cnt_d = m_last ? '0 : beat_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    committed <= 3'(RD_BUF_DEPTH));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));

endmodule
